// File: rtl/regfile32_32_pkg.sv
// Register-file sizing constants and the saturating write-counter helper.
// Pure declarations: no latency, no backpressure.
package regfile32_32_pkg;
`include "regfile32_32_defs.sv"

    localparam int ADDR_W    = `REG_ADDR_W;
    localparam int REG_COUNT = `REG_COUNT;
    localparam int WORD_W    = `WORD_W;
    localparam int CNT_W     = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 8'd1;
    endfunction
endpackage

// File: rtl/regfile32_32_if.sv
// Write port, two read ports and write counter of the register file.
// Reads are combinational and the write is accepted every cycle: no backpressure.
interface regfile32_32_if
    import regfile32_32_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (output we, wa, wd, ra1, ra2, input rd1, rd2, wr_cnt);
    modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2, wr_cnt);
endinterface

// File: rtl/mux32_32.sv
// 32:1 word multiplexer selecting one of i0..i31 by s.
// Combinational, zero latency; no backpressure.
module mux32_32
    import regfile32_32_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0]  i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,
    input  logic [WIDTH-1:0]  i8,  i9,  i10, i11, i12, i13, i14, i15,
    input  logic [WIDTH-1:0]  i16, i17, i18, i19, i20, i21, i22, i23,
    input  logic [WIDTH-1:0]  i24, i25, i26, i27, i28, i29, i30, i31,
    input  logic [ADDR_W-1:0] s,
    output logic [WIDTH-1:0]  y
);
    always_comb begin
        y = '0;
        case (s)
            5'd0:  y = i0;  5'd1:  y = i1;  5'd2:  y = i2;  5'd3:  y = i3;
            5'd4:  y = i4;  5'd5:  y = i5;  5'd6:  y = i6;  5'd7:  y = i7;
            5'd8:  y = i8;  5'd9:  y = i9;  5'd10: y = i10; 5'd11: y = i11;
            5'd12: y = i12; 5'd13: y = i13; 5'd14: y = i14; 5'd15: y = i15;
            5'd16: y = i16; 5'd17: y = i17; 5'd18: y = i18; 5'd19: y = i19;
            5'd20: y = i20; 5'd21: y = i21; 5'd22: y = i22; 5'd23: y = i23;
            5'd24: y = i24; 5'd25: y = i25; 5'd26: y = i26; 5'd27: y = i27;
            5'd28: y = i28; 5'd29: y = i29; 5'd30: y = i30; 5'd31: y = i31;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/regfile32_32_defs.sv
// Shared widths for the register file and its read muxes.
`ifndef REGFILE32_32_DEFS_SV
`define REGFILE32_32_DEFS_SV
`define REG_ADDR_W 5
`define REG_COUNT 32
`define WORD_W 32
`endif

// File: rtl/regfile32_32.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// Write visible through storage next cycle (same cycle via bypass); no backpressure.
module regfile32_32
    import regfile32_32_pkg::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile32_32_if.slave bus
);
    logic [WIDTH-1:0]     regs_q [REG_COUNT];
    logic [WIDTH-1:0]     regs_d [REG_COUNT];
    logic [CNT_W-1:0]     wr_cnt_q;
    logic [CNT_W-1:0]     wr_cnt_d;
    logic [REG_COUNT-1:0] wr_sel;
    logic                 commit;
    logic [WIDTH-1:0]     mux1_y;
    logic [WIDTH-1:0]     mux2_y;

    // rst_n gates commit so a write held during reset is neither stored nor forwarded
    always_comb begin
        commit = rst_n && bus.we && !(ZERO_REG && (bus.wa == '0));
        wr_sel = '0;
        wr_sel[bus.wa] = commit;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i] = wr_sel[i] ? bus.wd : regs_q[i];
        end
        wr_cnt_d = commit ? sat_inc(wr_cnt_q) : wr_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    mux32_32 #(.WIDTH(WIDTH)) u_mux1 (
        .i0 (regs_q[0]),  .i1 (regs_q[1]),  .i2 (regs_q[2]),  .i3 (regs_q[3]),
        .i4 (regs_q[4]),  .i5 (regs_q[5]),  .i6 (regs_q[6]),  .i7 (regs_q[7]),
        .i8 (regs_q[8]),  .i9 (regs_q[9]),  .i10(regs_q[10]), .i11(regs_q[11]),
        .i12(regs_q[12]), .i13(regs_q[13]), .i14(regs_q[14]), .i15(regs_q[15]),
        .i16(regs_q[16]), .i17(regs_q[17]), .i18(regs_q[18]), .i19(regs_q[19]),
        .i20(regs_q[20]), .i21(regs_q[21]), .i22(regs_q[22]), .i23(regs_q[23]),
        .i24(regs_q[24]), .i25(regs_q[25]), .i26(regs_q[26]), .i27(regs_q[27]),
        .i28(regs_q[28]), .i29(regs_q[29]), .i30(regs_q[30]), .i31(regs_q[31]),
        .s  (bus.ra1),    .y  (mux1_y)
    );

    mux32_32 #(.WIDTH(WIDTH)) u_mux2 (
        .i0 (regs_q[0]),  .i1 (regs_q[1]),  .i2 (regs_q[2]),  .i3 (regs_q[3]),
        .i4 (regs_q[4]),  .i5 (regs_q[5]),  .i6 (regs_q[6]),  .i7 (regs_q[7]),
        .i8 (regs_q[8]),  .i9 (regs_q[9]),  .i10(regs_q[10]), .i11(regs_q[11]),
        .i12(regs_q[12]), .i13(regs_q[13]), .i14(regs_q[14]), .i15(regs_q[15]),
        .i16(regs_q[16]), .i17(regs_q[17]), .i18(regs_q[18]), .i19(regs_q[19]),
        .i20(regs_q[20]), .i21(regs_q[21]), .i22(regs_q[22]), .i23(regs_q[23]),
        .i24(regs_q[24]), .i25(regs_q[25]), .i26(regs_q[26]), .i27(regs_q[27]),
        .i28(regs_q[28]), .i29(regs_q[29]), .i30(regs_q[30]), .i31(regs_q[31]),
        .s  (bus.ra2),    .y  (mux2_y)
    );

    assign bus.rd1    = (BYPASS && commit && (bus.wa == bus.ra1)) ? bus.wd : mux1_y;
    assign bus.rd2    = (BYPASS && commit && (bus.wa == bus.ra2)) ? bus.wd : mux2_y;
    assign bus.wr_cnt = wr_cnt_q;
endmodule

// File: doc/regfile32_32.md
Name: regfile32_32

Overview:
- 32-entry x 32-bit register file; the storage stage directly upstream of the 32-bit 32:1 mux.
- Holds the register contents and drives them as the 32 mux data inputs (i0..i31).
- Two read ports, each built from one 32:1 mux, plus one synchronous write port with a 5-to-32 decoder.
- Sits in the CPU datapath between write-back, which feeds it, and operand fetch/ALU, which consume it.

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are ignored.
- BYPASS, 1, when 1 a same-cycle write to the register being read is forwarded to the read port.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on rising clk.
- wa  input  5  write address.
- wd  input  WIDTH  write data.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  WIDTH  read data, port 1; combinational from ra1 and storage (and bypass).
- rd2  output  WIDTH  read data, port 2; same rules as rd1.
- wr_cnt  output  8  count of committed writes, saturating at 8'hFF.

Behaviour:
- Reset: rst_n low asynchronously clears all 32 registers and wr_cnt to 0, so rd1/rd2 read 0 while reset is held.
- Write: on a rising clk with rst_n high and we=1, reg[wa] <= wd. The new value is visible through storage from the next cycle (one cycle write latency).
- Register 0: if ZERO_REG=1 and wa=0, no storage update, no bypass, and wr_cnt does not increment. reg[0] always reads 0.
- Read: rd1 = mux(reg[0..31], ra1); rd2 = mux(reg[0..31], ra2). There is no read latency, and both ports may hit the same address.
- Bypass: if BYPASS=1, we=1, wa==raN and wa!=0 (when ZERO_REG=1), then rdN = wd in the same cycle. If BYPASS=0, rdN shows the old value until the edge.
- wr_cnt: increments by 1 per committed write and holds at 255. A write with we=0 or to a suppressed r0 does not count.
- Reset mid-operation: asserting rst_n overrides any write in that cycle; nothing commits.
- Deassertion: release of rst_n is synchronized externally. The first edge after release may commit a write.
- Simultaneous events: only one write port exists, so there is no write-write conflict. Read and write to the same address follows the bypass rule above.
- Timing: no X allowed on rd1/rd2 after reset. wa, ra1 and ra2 are always in range; they are 5 bits, so there is no wrap-around case.

Decomposition:
- Shared include file: `define REG_ADDR_W 5, `define REG_COUNT 32, `define WORD_W 32.
- Sub-module: reuse the existing mux32_32, instantiated twice (one per read port) with the 32 register outputs as i0..i31 and raN as s.
- The write decoder, storage and bypass logic stay inline in regfile32_32.

Test Plan:
1. Reset: hold rst_n=0, sweep ra1 over 0..31 -> rd1=0 for every address, wr_cnt=0.
2. Write/readback: for k=1..31, write wd=32'hA5A50000+k to wa=k, then read ra1=k, ra2=31-k -> rd1=32'hA5A50000+k. rd2 matches its own written value, or 0 for address 0. wr_cnt=31.
3. Register 0: we=1, wa=0, wd=32'hFFFFFFFF; read ra1=0 -> rd1=0 in the same cycle and the next, wr_cnt unchanged.
4. Bypass: reg[5]=32'h1; in one cycle drive we=1, wa=5, wd=32'h12345678, ra1=5 -> rd1=32'h12345678 before the edge with BYPASS=1. With BYPASS=0, rd1=32'h1 before the edge and 32'h12345678 after.
5. Async reset mid-write: fill reg[7]=32'hDEADBEEF; pulse rst_n low between edges while we=1 -> rd1(ra1=7)=0 immediately, and the pending write is not committed.
6. Counter saturation: 300 consecutive writes to wa=3 -> wr_cnt=8'hFF and holds; rd1(ra1=3) equals the last wd.
